// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD card SPI byte controller.
package sd_spi_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  localparam logic [7:0] RX_RESET  = 8'hFF;
  localparam logic       MOSI_IDLE = 1'b1;
endpackage

// File: rtl/sd_spi_halfcnt.sv
// Loadable down-counter that times each SCLK half-period.
module sd_spi_halfcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge clr_n) begin
    if (clr_n)     cnt <= '0;
    else if (load) cnt <= value;
    else if (dec)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/sd_spi_byte_ctrl.sv
// SPI mode-0 byte transfer engine for the SD socket: SCLK divider, shift
// register, chip-select register and busy/done handshake.
module sd_spi_byte_ctrl
  import sd_spi_pkg::*;
#(
  parameter int   DIV_W    = 8,
  parameter logic CS_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [7:0]       tx_data,
  input  logic [DIV_W-1:0] div,
  input  logic             cs_wr,
  input  logic             cs_val,
  input  logic             miso,
  output logic             sclk,
  output logic             mosi,
  output logic             cs_n,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rx_data
);
  state_t           state, state_d;
  logic [7:0]       shreg, shreg_d, rx_d;
  logic [2:0]       bitn, bitn_d;
  logic [DIV_W-1:0] div_q, div_q_d, hc_val;
  logic             rbit, rbit_d, sclk_d, mosi_d, cs_d, busy_d, done_d;
  logic             hc_load, hc_dec, hc_zero;

  sd_spi_halfcnt #(.W(DIV_W)) u_halfcnt (
    .clk   (clk),
    .clr_n (clr_n),
    .load  (hc_load),
    .dec   (hc_dec),
    .value (hc_val),
    .zero  (hc_zero)
  );

  always_ff @(posedge clk or posedge clr_n) begin
    if (clr_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bitn    <= '0;
      div_q   <= '0;
      rbit    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= MOSI_IDLE;
      cs_n    <= CS_RESET;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= RX_RESET;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bitn    <= bitn_d;
      div_q   <= div_q_d;
      rbit    <= rbit_d;
      sclk    <= sclk_d;
      mosi    <= mosi_d;
      cs_n    <= cs_d;
      busy    <= busy_d;
      done    <= done_d;
      rx_data <= rx_d;
    end
  end

  always_comb begin
    state_d = state;
    shreg_d = shreg;
    bitn_d  = bitn;
    div_q_d = div_q;
    rbit_d  = rbit;
    sclk_d  = sclk;
    mosi_d  = mosi;
    cs_d    = cs_n;
    busy_d  = busy;
    done_d  = 1'b0;
    rx_d    = rx_data;
    hc_load = 1'b0;
    hc_dec  = 1'b0;
    hc_val  = div_q;
    unique case (state)
      IDLE: begin
        // CS write lands before the first LOW phase, giving card setup time
        if (cs_wr) cs_d = cs_val;
        if (start) begin
          shreg_d = tx_data;
          mosi_d  = tx_data[7];
          div_q_d = div;
          hc_val  = div;
          hc_load = 1'b1;
          bitn_d  = '0;
          busy_d  = 1'b1;
          state_d = LOW;
        end
      end
      LOW: begin
        if (!hc_zero) hc_dec = 1'b1;
        else begin
          sclk_d  = 1'b1;
          rbit_d  = miso;
          hc_load = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (!hc_zero) hc_dec = 1'b1;
        else begin
          sclk_d  = 1'b0;
          shreg_d = {shreg[6:0], rbit};
          hc_load = 1'b1;
          if (bitn == 3'd7) begin
            // done/rx_data go out with the last busy cycle
            rx_d    = {shreg[6:0], rbit};
            done_d  = 1'b1;
            mosi_d  = MOSI_IDLE;
            state_d = DONE;
          end else begin
            bitn_d  = bitn + 3'd1;
            mosi_d  = shreg[6];
            state_d = LOW;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sd_spi_byte_ctrl.sv
// Self-checking bench for sd_spi_byte_ctrl: vector table, corner sequences
// and random transfers against a byte-level card/loopback model.
module tb_sd_spi_byte_ctrl;
  logic       clk = 1'b0, clr_n = 1'b1;
  logic       start = 1'b0, cs_wr = 1'b0, cs_val = 1'b0, miso;
  logic [7:0] tx_data = 8'h00, div = 8'h00;
  logic       sclk, mosi, cs_n, busy, done;
  logic [7:0] rx_data;

  int n_chk = 0, n_fail = 0;

  // card model state (owned by the initial block)
  logic [7:0] card_byte = 8'h00;
  logic       loopback = 1'b0;

  // monitor state (owned by the monitor process)
  int rise_cnt = 0, busy_cyc = 0, done_cnt = 0, mosi_viol = 0;
  int run = 0, ph_min = 'hFFFF, ph_max = 0;
  logic [7:0] mosi_sr = 8'h00;
  logic psclk = 1'b0, pmosi = 1'b1;

  sd_spi_byte_ctrl #(.DIV_W(8), .CS_RESET(1'b1)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .tx_data(tx_data), .div(div),
    .cs_wr(cs_wr), .cs_val(cs_val), .miso(miso), .sclk(sclk), .mosi(mosi),
    .cs_n(cs_n), .busy(busy), .done(done), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  // card presents bit (7 - rising edges seen so far), MSB first
  always_comb begin
    int k;
    k = (rise_cnt > 7) ? 0 : 7 - rise_cnt;
    miso = loopback ? mosi : card_byte[k[2:0]];
  end

  always @(negedge clk) begin
    if (start && !busy && !clr_n) begin
      rise_cnt <= 0; busy_cyc <= 0; done_cnt <= 0; mosi_viol <= 0;
      run <= 0; ph_min <= 'hFFFF; ph_max <= 0; mosi_sr <= 8'h00;
    end else begin
      if (sclk && !psclk) begin
        rise_cnt <= rise_cnt + 1;
        mosi_sr  <= {mosi_sr[6:0], mosi};
      end
      if (busy) busy_cyc <= busy_cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (mosi != pmosi && sclk) mosi_viol <= mosi_viol + 1;
      if (!busy) run <= 0;
      else if (sclk != psclk) begin
        if (run < ph_min) ph_min <= run;
        if (run > ph_max) ph_max <= run;
        run <= 1;
      end else run <= run + 1;
    end
    psclk <= sclk;
    pmosi <= mosi;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] tx, input int dv, input logic cw, input logic cv);
    @(posedge clk); #1;
    start = 1'b1; tx_data = tx; div = 8'(dv); cs_wr = cw; cs_val = cv;
    @(posedge clk); #1;
    start = 1'b0; cs_wr = 1'b0; tx_data = 8'($urandom); div = 8'($urandom);
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_xfer(input string nm, input logic [7:0] tx, input int dv,
                         input logic [7:0] card, input logic lp,
                         input logic [7:0] exp_rx, input int exp_busy);
    bit ok;
    card_byte = card; loopback = lp;
    pulse_start(tx, dv, 1'b0, 1'b0);
    wait_done(exp_busy + 10, ok);
    chk({nm, " done_seen"}, 32'(ok), 32'd1);
    chk({nm, " rx_data"}, 32'(rx_data), 32'(exp_rx));
    chk({nm, " busy_with_done"}, 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    chk({nm, " busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
    chk({nm, " done_pulses"}, 32'(done_cnt), 32'd1);
    chk({nm, " sclk_rises"}, 32'(rise_cnt), 32'd8);
    chk({nm, " mosi_bits"}, 32'(mosi_sr), 32'(tx));
    chk({nm, " phase_min"}, 32'(ph_min), 32'(dv + 1));
    chk({nm, " phase_max"}, 32'(ph_max), 32'(dv + 1));
    chk({nm, " mosi_stable"}, 32'(mosi_viol), 32'd0);
    chk({nm, " idle_after"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] tx;
    int         dv;
    logic [7:0] card;
    logic       lp;
    logic [7:0] exp_rx;
    int         exp_busy;
  } vec_t;

  initial begin
    vec_t vt[5];
    bit ok;
    vt[0] = '{8'hA5, 0,   8'h00, 1'b1, 8'hA5, 17};
    vt[1] = '{8'h3C, 3,   8'hC3, 1'b0, 8'hC3, 65};
    vt[2] = '{8'h00, 0,   8'h5A, 1'b0, 8'h5A, 17};
    vt[3] = '{8'hFF, 1,   8'h81, 1'b0, 8'h81, 33};
    vt[4] = '{8'h96, 255, 8'h2D, 1'b0, 8'h2D, 4097};

    // reset
    repeat (3) @(posedge clk);
    #1 clr_n = 1'b0;
    @(negedge clk);
    chk("rst sclk", 32'(sclk), 32'd0);
    chk("rst mosi", 32'(mosi), 32'd1);
    chk("rst cs_n", 32'(cs_n), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst rx_data", 32'(rx_data), 32'hFF);

    for (int i = 0; i < 5; i++)
      do_xfer($sformatf("vec%0d", i), vt[i].tx, vt[i].dv, vt[i].card, vt[i].lp,
              vt[i].exp_rx, vt[i].exp_busy);

    // cs write with start, then start + cs_wr mid-byte and start during DONE are ignored
    card_byte = 8'h69; loopback = 1'b0;
    pulse_start(8'h5A, 2, 1'b1, 1'b0);
    @(negedge clk);
    chk("ign cs_low", 32'(cs_n), 32'd0);
    repeat (10) @(posedge clk);
    #1 start = 1'b1; tx_data = 8'hFF; cs_wr = 1'b1; cs_val = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; cs_wr = 1'b0;
    @(negedge clk);
    chk("ign cs_hold", 32'(cs_n), 32'd0);
    wait_done(80, ok);
    chk("ign done_seen", 32'(ok), 32'd1);
    chk("ign rx_data", 32'(rx_data), 32'h69);
    start = 1'b1; tx_data = 8'h00;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    chk("ign no_second", 32'(busy), 32'd0);
    chk("ign done_pulses", 32'(done_cnt), 32'd1);
    chk("ign busy_cycles", 32'(busy_cyc), 32'd49);
    chk("ign mosi_bits", 32'(mosi_sr), 32'h5A);
    chk("ign cs_after", 32'(cs_n), 32'd0);

    // reset mid-transfer after 5 SCLK rises
    card_byte = 8'hE7;
    pulse_start(8'h81, 1, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rise_cnt >= 5) begin ok = 1'b1; break; end
    end
    chk("rmid reached", 32'(ok), 32'd1);
    @(posedge clk);
    #2 clr_n = 1'b1;
    #1;
    chk("rmid sclk", 32'(sclk), 32'd0);
    chk("rmid mosi", 32'(mosi), 32'd1);
    chk("rmid cs_n", 32'(cs_n), 32'd1);
    chk("rmid busy", 32'(busy), 32'd0);
    chk("rmid done", 32'(done), 32'd0);
    chk("rmid rx_data", 32'(rx_data), 32'hFF);
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b0;
    repeat (40) @(negedge clk);
    chk("rmid no_done", 32'(done_cnt), 32'd0);
    chk("rmid idle", 32'(busy), 32'd0);
    do_xfer("rmid after", 8'hC4, 2, 8'h3B, 1'b0, 8'h3B, 49);

    // back-to-back: start in the cycle right after done
    card_byte = 8'h00; loopback = 1'b1;
    pulse_start(8'h00, 0, 1'b0, 1'b0);
    wait_done(30, ok);
    chk("b2b first_done", 32'(ok), 32'd1);
    chk("b2b first_rx", 32'(rx_data), 32'h00);
    @(posedge clk);
    #1 start = 1'b1; tx_data = 8'hFF; div = 8'h00;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("b2b second_busy", 32'(busy), 32'd1);
    wait_done(30, ok);
    chk("b2b second_done", 32'(ok), 32'd1);
    chk("b2b second_rx", 32'(rx_data), 32'hFF);
    repeat (2) @(negedge clk);
    chk("b2b busy_cycles", 32'(busy_cyc), 32'd17);
    chk("b2b done_pulses", 32'(done_cnt), 32'd1);

    // random transfers against the byte-level model
    for (int i = 0; i < 16; i++) begin
      logic [7:0] tx, cb;
      logic       lp;
      int         dv;
      tx = 8'($urandom); cb = 8'($urandom);
      lp = 1'($urandom_range(0, 1)); dv = $urandom_range(0, 5);
      do_xfer($sformatf("rnd%0d", i), tx, dv, cb, lp, lp ? tx : cb, 16 * (dv + 1) + 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
